// File: rtl/bldc_drive_sequencer.sv
// Six-gate BLDC bridge sequencer: hall sync/debounce, edge-aligned PWM, six-step commutation,
// dead-time enforcement and latched faults. Define BLDC_BRAKE_EN for dynamic braking on a zero command.
module bldc_drive_sequencer #(
  parameter int unsigned PWM_BITS     = 9,
  parameter int unsigned DEADTIME     = 8,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned STALL_CYCLES = 16000000
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [PWM_BITS:0] pwm,
  input  logic              hall1,
  input  logic              hall2,
  input  logic              hall3,
  input  logic              clear_fault,
  output logic [5:0]        GATES,
  output logic [1:0]        state,
  output logic [1:0]        fault_code,
  output logic [2:0]        hall_state
);

  localparam int unsigned CMD_W = PWM_BITS + 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 2);
  localparam int unsigned DT_W  = $clog2(DEADTIME + 2);
  localparam int unsigned ST_W  = $clog2(STALL_CYCLES + 1);

  localparam logic [DB_W-1:0]     DB_MAX  = DB_W'(DEBOUNCE);
  localparam logic [DT_W-1:0]     DT_MAX  = DT_W'(DEADTIME);
  localparam logic [ST_W-1:0]     ST_LAST = ST_W'(STALL_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DEAD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sync1_q, sync2_q, prev_q, hall_nxt_c;
  logic [DB_W-1:0]     db_cnt_q, run_c;
  logic [PWM_BITS-1:0] pwm_cnt_q, mag_c;
  logic [PWM_BITS:0]   abs_c;
  logic                on_c, hall_bad_c, active_c, qual_c, stall_hit_c, off_rst_c;
  logic [5:0]          target_c, gates_d;
  logic [1:0]          fault_d;
  logic [DT_W-1:0]     off_cnt_q;
  logic [ST_W-1:0]     stall_cnt_q;

  assign state = state_q;

  // Forward six-step pattern per hall code; reverse swaps high/low within each phase.
  function automatic logic [5:0] comm(input logic [2:0] h, input logic rev);
    logic [5:0] f;
    case (h)
      3'b101:  f = 6'b100100;
      3'b100:  f = 6'b100001;
      3'b110:  f = 6'b001001;
      3'b010:  f = 6'b011000;
      3'b011:  f = 6'b010010;
      3'b001:  f = 6'b000110;
      default: f = 6'b000000;
    endcase
    return rev ? {f[4], f[5], f[2], f[3], f[0], f[1]} : f;
  endfunction

  // run_c = consecutive cycles the synced code has held, including this one.
  always_comb begin
    run_c      = (sync2_q == prev_q) ? db_cnt_q + DB_W'(1) : DB_W'(1);
    hall_nxt_c = (run_c >= DB_MAX) ? sync2_q : hall_state;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      db_cnt_q   <= '0;
      hall_state <= '0;
    end else begin
      sync1_q    <= {hall1, hall2, hall3};
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      db_cnt_q   <= (run_c > DB_MAX) ? DB_MAX : run_c;
      hall_state <= hall_nxt_c;
    end
  end

  // Magnitude of the signed command; the most negative code clamps to full scale.
  always_comb begin
    abs_c = pwm[PWM_BITS] ? (~pwm + CMD_W'(1)) : pwm;
    mag_c = abs_c[PWM_BITS] ? MAG_MAX : abs_c[PWM_BITS-1:0];
    on_c  = (mag_c != '0) && (pwm_cnt_q < mag_c);
  end

  always_comb begin
    target_c = on_c ? comm(hall_state, pwm[PWM_BITS]) : 6'b000000;
`ifdef BLDC_BRAKE_EN
    if (mag_c == '0) target_c = 6'b010101;
`endif
  end

  always_comb begin
    hall_bad_c  = (hall_state == 3'b000) || (hall_state == 3'b111);
    active_c    = (state_q == S_RUN) || (state_q == S_DEAD);
    qual_c      = active_c && (mag_c != '0) && (hall_nxt_c == hall_state);
    stall_hit_c = qual_c && (stall_cnt_q == ST_LAST);
  end

  // Next state, next gate pattern and fault code.
  always_comb begin
    state_d   = state_q;
    gates_d   = 6'b000000;
    fault_d   = fault_code;
    off_rst_c = 1'b0;
    case (state_q)
      S_FAULT: begin
        if (clear_fault) begin
          state_d   = S_IDLE;
          fault_d   = 2'b00;
          off_rst_c = 1'b1;
        end
      end
      default: begin
        if (enable && hall_bad_c) begin
          state_d = S_FAULT;
          fault_d = 2'b01;
        end else if (stall_hit_c) begin
          state_d = S_FAULT;
          fault_d = 2'b10;
        end else if (state_q == S_IDLE) begin
          if (enable) state_d = S_RUN;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (target_c == 6'b000000) begin
          state_d = S_RUN;
        end else if (target_c == GATES) begin
          gates_d = target_c;
          state_d = S_RUN;
        end else if (GATES != 6'b000000) begin
          state_d = S_DEAD;
        end else if (off_cnt_q >= DT_MAX) begin
          gates_d = target_c;
          state_d = S_RUN;
        end else begin
          state_d = S_DEAD;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      GATES      <= '0;
      fault_code <= '0;
    end else begin
      state_q    <= state_d;
      GATES      <= gates_d;
      fault_code <= fault_d;
    end
  end

  // off_cnt_q = consecutive cycles GATES has been all-zero, including the current one.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pwm_cnt_q   <= '0;
      off_cnt_q   <= DT_MAX;
      stall_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (off_rst_c || (gates_d != 6'b000000)) off_cnt_q <= '0;
      else if (off_cnt_q < DT_MAX)             off_cnt_q <= off_cnt_q + DT_W'(1);
      if (qual_c && ((state_d == S_RUN) || (state_d == S_DEAD)))
        stall_cnt_q <= stall_cnt_q + ST_W'(1);
      else
        stall_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// Bench for bldc_drive_sequencer: directed scenarios plus random stimulus, every cycle compared
// against a behavioural model of the sequencer kept in the bench.
module tb_bldc_drive_sequencer;

  localparam int PWM_BITS = 9;
  localparam int CW       = PWM_BITS + 1;
  localparam int DEADTIME = 8;
  localparam int DEBOUNCE = 4;
  localparam int STALL    = 1000;
  localparam int PMAX     = (1 << PWM_BITS) - 1;

  logic          CLK = 1'b0;
  logic          reset, enable, clear_fault, hall1, hall2, hall3;
  logic [CW-1:0] pwm;
  logic [5:0]    GATES;
  logic [1:0]    state, fault_code;
  logic [2:0]    hall_state;

  bldc_drive_sequencer #(
    .PWM_BITS(PWM_BITS), .DEADTIME(DEADTIME), .DEBOUNCE(DEBOUNCE), .STALL_CYCLES(STALL)
  ) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .pwm(pwm),
    .hall1(hall1), .hall2(hall2), .hall3(hall3), .clear_fault(clear_fault),
    .GATES(GATES), .state(state), .fault_code(fault_code), .hall_state(hall_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // Phase driven high / low for each hall code in forward rotation (0=A, 1=B, 2=C).
  int HI [8] = '{-1, 2, 1, 2, 0, 0, 1, -1};
  int LO [8] = '{-1, 1, 0, 0, 2, 1, 2, -1};
  int VALID [6] = '{1, 2, 3, 4, 5, 6};

  int m_rawq [2];
  int m_synq [$];
  int m_hall, m_cnt, m_gates, m_state, m_fault, m_zero, m_stall;

  function automatic int pattern(int h, bit rev);
    int hi, lo, t;
    if (h == 0 || h == 7) return 0;
    hi = HI[h];
    lo = LO[h];
    if (rev) begin t = hi; hi = lo; lo = t; end
    return (1 << (5 - 2 * hi)) | (1 << (4 - 2 * lo));
  endfunction

  task automatic model_reset();
    m_rawq[0] = 0; m_rawq[1] = 0;
    m_synq.delete();
    m_hall = 0; m_cnt = 0; m_gates = 0; m_state = 0; m_fault = 0;
    m_zero = DEADTIME; m_stall = 0;
  endtask

  task automatic model_step();
    int syn, hall_nx, p, mag, tgt, nst, ngates, nfault;
    bit on, bad, act, qual, hit, clr, ok, stable;
    syn = m_rawq[1];
    m_synq.push_front(syn);
    if (m_synq.size() > DEBOUNCE) void'(m_synq.pop_back());
    stable = (m_synq.size() == DEBOUNCE);
    foreach (m_synq[i]) if (m_synq[i] != syn) stable = 0;
    hall_nx = stable ? syn : m_hall;

    p   = int'($signed(pwm));
    mag = (p < 0) ? -p : p;
    if (mag > PMAX) mag = PMAX;
    on  = (mag != 0) && (m_cnt < mag);
    tgt = on ? pattern(m_hall, p < 0) : 0;
`ifdef BLDC_BRAKE_EN
    if (mag == 0) tgt = 'b010101;
`endif
    bad  = enable && (m_hall == 0 || m_hall == 7);
    act  = (m_state == 1 || m_state == 2);
    qual = act && (mag != 0) && (hall_nx == m_hall);
    hit  = qual && (m_stall + 1 >= STALL);

    nst = m_state; ngates = 0; nfault = m_fault; clr = 0;
    if (m_state == 3) begin
      if (clear_fault) begin nst = 0; nfault = 0; clr = 1; end
    end else if (bad) begin
      nst = 3; nfault = 1;
    end else if (hit) begin
      nst = 3; nfault = 2;
    end else if (m_state == 0) begin
      if (enable) nst = 1;
    end else if (!enable) begin
      nst = 0;
    end else begin
      ok     = (tgt == m_gates) || (m_gates == 0 && m_zero >= DEADTIME);
      ngates = ok ? tgt : 0;
      nst    = (tgt != 0 && !ok) ? 2 : 1;
    end

    m_stall = (qual && (nst == 1 || nst == 2)) ? m_stall + 1 : 0;
    if (clr || ngates != 0) m_zero = 0;
    else if (m_zero < DEADTIME) m_zero++;
    m_cnt   = (m_cnt + 1) % (PMAX + 1);
    m_hall  = hall_nx; m_gates = ngates; m_state = nst; m_fault = nfault;
    m_rawq[1] = m_rawq[0];
    m_rawq[0] = int'({hall1, hall2, hall3});
  endtask

  task automatic compare();
    checks++;
    if (GATES === 6'(m_gates) && state === 2'(m_state) &&
        fault_code === 2'(m_fault) && hall_state === 3'(m_hall)) passes++;
    else $display("FAIL model t=%0t GATES=%b want %b state=%0d want %0d fault=%b want %b hall=%b want %b",
                  $time, GATES, 6'(m_gates), state, m_state, fault_code, 2'(m_fault), hall_state, 3'(m_hall));
    checks++;
    if (((GATES >> 1) & GATES & 6'b010101) == 6'b000000) passes++;
    else $display("FAIL shoot_through t=%0t GATES=%b has an H/L pair on", $time, GATES);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    if (reset) model_reset(); else model_step();
    #1;
    compare();
  endtask

  task automatic set_hall(input int h);
    {hall1, hall2, hall3} = 3'(h);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, zrun, zeros;
    bit found, seen_dead;
    logic [5:0] prev_g;

    reset = 1'b1; enable = 1'b0; clear_fault = 1'b0; pwm = '0; set_hall(5);
    model_reset();
    repeat (3) tick();
    lit("reset_gates", int'(GATES), 0);
    lit("reset_state", int'(state), 0);
    lit("reset_fault", int'(fault_code), 0);
    lit("reset_hall", int'(hall_state), 0);
    reset = 1'b0;
    repeat (8) tick();
    lit("hall_debounced", int'(hall_state), 5);

    // Forward drive: 100 of every 512 cycles on.
    pwm = CW'(100); enable = 1'b1;
    tick();
    lit("run_entry", int'(state), 1);
    n = 0;
    repeat (512) begin tick(); if (GATES == 6'b100100) n++; end
    lit("fwd_duty", n, 100);

    // Reverse with a commutation step inside the on phase.
    pwm = CW'(-100);
    set_hall(1); repeat (20) tick();
    set_hall(5); repeat (20) tick();
    found = 0; zrun = 0;
    for (int i = 0; i < 1100 && !found; i++) begin
      tick();
      if (GATES == 6'b000000) zrun++;
      else if (GATES == 6'b011000 && zrun > 20) found = 1;
      else zrun = 0;
    end
    lit("rev_start_found", int'(found), 1);
    set_hall(4);
    found = 0; zeros = 0; seen_dead = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (GATES == 6'b000000) begin zeros++; if (state == 2'd2) seen_dead = 1; end
      else if (GATES == 6'b010010) found = 1;
    end
    lit("rev_new_pattern", int'(found), 1);
    lit("rev_dead_zeros", zeros, DEADTIME);
    lit("rev_dead_state", int'(seen_dead), 1);

    // Most negative command: full scale, dead time stretches the 1-cycle off phase.
    pwm = CW'(-512); set_hall(6);
    repeat (10) tick();
    found = 0; prev_g = GATES;
    for (int i = 0; i < 530 && !found; i++) begin
      tick();
      if (prev_g != 6'b000000 && GATES == 6'b000000) found = 1;
      prev_g = GATES;
    end
    lit("maxneg_fall_found", int'(found), 1);
    zeros = 1;
    for (int i = 0; i < 40 && GATES == 6'b000000; i++) begin
      tick();
      if (GATES == 6'b000000) zeros++;
    end
    lit("maxneg_off_cycles", zeros, DEADTIME);
    lit("maxneg_pattern", int'(GATES), 'b000110);

    // Asynchronous reset while driving.
    async_reset();
    lit("async_gates", int'(GATES), 0);
    lit("async_state", int'(state), 0);
    lit("async_fault", int'(fault_code), 0);
    repeat (5) tick();
    lit("reset_hold_gates", int'(GATES), 0);
    lit("reset_hold_state", int'(state), 0);
    reset = 1'b0; enable = 1'b0; pwm = CW'(100); set_hall(5);
    repeat (10) tick();
    enable = 1'b1;
    repeat (5) tick();

    // Invalid hall fault, sticky until cleared.
    set_hall(7);
    repeat (10) tick();
    lit("inv_state", int'(state), 3);
    lit("inv_fault", int'(fault_code), 1);
    lit("inv_gates", int'(GATES), 0);
    set_hall(5);
    repeat (10) tick();
    lit("inv_sticky", int'(fault_code), 1);
    pulse_clear();
    lit("clear_idle", int'(state), 0);
    lit("clear_code", int'(fault_code), 0);
    tick();
    lit("clear_run", int'(state), 1);

    // Clear while the invalid code persists re-faults on the next cycle.
    set_hall(7);
    repeat (10) tick();
    pulse_clear();
    lit("reclear_idle", int'(state), 0);
    tick();
    lit("refault_state", int'(state), 3);
    lit("refault_code", int'(fault_code), 1);

    // Stall: constant halls with nonzero command.
    set_hall(1); pwm = CW'(50);
    repeat (10) tick();
    pulse_clear();
    n = 0;
    for (int i = 0; i < 1200 && state != 2'd3; i++) begin
      tick();
      if (state == 2'd1 || state == 2'd2) n++;
    end
    lit("stall_cycles", n, STALL);
    lit("stall_code", int'(fault_code), 2);

    // Zero command for longer than the stall window.
    pwm = '0;
    pulse_clear();
    repeat (1200) tick();
    lit("zero_cmd_state", int'(state), 1);
    lit("zero_cmd_fault", int'(fault_code), 0);
`ifdef BLDC_BRAKE_EN
    lit("brake_gates", int'(GATES), 'b010101);
`else
    lit("coast_gates", int'(GATES), 0);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 9) == 0) set_hall($urandom_range(0, 1) ? 7 : 0);
        else set_hall(VALID[$urandom_range(0, 5)]);
      end
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 5))
          0: pwm = '0;
          1: pwm = CW'(-512);
          2: pwm = CW'(511);
          3: pwm = CW'($urandom_range(0, 1023));
          4: pwm = CW'(int'($urandom_range(1, 30)));
          default: pwm = CW'(-int'($urandom_range(490, 512)));
        endcase
      end
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      clear_fault = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2999) == 0) begin
        async_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
